// File: rtl/otter_fetch_pkg.sv
// Shared types and constants for the OTTER instruction-fetch front end.
package otter_fetch_pkg;

    localparam logic [31:0] INSTR_BYTES = 32'd4;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] ir;
    } fetch_entry_t;

    typedef enum logic [6:0] {
        OP_LOAD   = 7'b0000011,
        OP_IMM    = 7'b0010011,
        OP_AUIPC  = 7'b0010111,
        OP_STORE  = 7'b0100011,
        OP_REG    = 7'b0110011,
        OP_LUI    = 7'b0110111,
        OP_BRANCH = 7'b1100011,
        OP_JALR   = 7'b1100111,
        OP_JAL    = 7'b1101111,
        OP_SYS    = 7'b1110011
    } opcode_t;

endpackage

// File: rtl/otter_fetch_fifo.sv
// Small circular queue of fetched {pc, ir} entries with a separate occupancy count.
module otter_fetch_fifo
    import otter_fetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   clear,
    input  fetch_entry_t           din,
    output fetch_entry_t           dout,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);

    localparam int AW = $clog2(DEPTH);

    fetch_entry_t  mem [DEPTH];
    fetch_entry_t  last_head;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_push = push && !clear && !full;
    assign do_pop  = pop && !clear && !empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            if (do_push && !do_pop)
                count <= count + (AW+1)'(1);
            else if (!do_push && do_pop)
                count <= count - (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    // Remember the presented head so the outputs hold steady once the queue drains.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            last_head <= '0;
        else if (!empty)
            last_head <= mem[rd_ptr];
    end

    assign dout = empty ? last_head : mem[rd_ptr];

endmodule

// File: rtl/otter_fetch_buffer.sv
// Fetch front end: owns the fetch PC, issues credit-limited reads to instruction
// memory, queues the returned words and flushes everything on an execute redirect.
module otter_fetch_buffer
    import otter_fetch_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                   CLK,
    input  logic                   RST_N,
    output logic [31:0]            IMEM_ADDR,
    output logic                   IMEM_RDEN,
    input  logic [31:0]            IMEM_DOUT,
    input  logic                   REDIRECT,
    input  logic [31:0]            REDIRECT_PC,
    input  logic                   DE_READY,
    output logic                   DE_VALID,
    output logic [31:0]            DE_PC,
    output logic [31:0]            DE_IR,
    output logic [31:0]            DE_PCPLUS4,
    output logic [$clog2(DEPTH):0] BUF_COUNT
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic [31:0]   fpc;
    logic [31:0]   req_pc;
    logic          inflight;
    logic          kill;
    logic          issue;
    logic          push;
    logic          pop;
    logic          full;
    logic          empty;
    logic [CW-1:0] count;
    logic [CW:0]   credit_used;
    fetch_entry_t  head;
    fetch_entry_t  entry;
    logic          unused_redirect_bits;

    assign unused_redirect_bits = ^REDIRECT_PC[1:0];

    assign pop  = !empty && DE_READY && !REDIRECT;
    assign push = inflight && !kill && !REDIRECT;

    // A read is only issued when its response is guaranteed a free slot; held off during reset.
    assign credit_used = {1'b0, count} + {{CW{1'b0}}, inflight} - {{CW{1'b0}}, pop};
    assign issue       = RST_N && (REDIRECT || (credit_used < (CW+1)'(DEPTH)));

    assign IMEM_RDEN = issue;
    assign IMEM_ADDR = REDIRECT ? {REDIRECT_PC[31:2], 2'b00} : fpc;
    assign entry     = '{pc: req_pc, ir: IMEM_DOUT};

    // kill never rises: a redirect drops its own-cycle response and the next one is the target's.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            fpc      <= RESET_PC;
            req_pc   <= '0;
            inflight <= 1'b0;
            kill     <= 1'b0;
        end else begin
            inflight <= issue;
            kill     <= 1'b0;
            if (issue) begin
                fpc    <= IMEM_ADDR + INSTR_BYTES;
                req_pc <= IMEM_ADDR;
            end
        end
    end

    otter_fetch_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk   (CLK),
        .rst_n (RST_N),
        .push  (push),
        .pop   (pop),
        .clear (REDIRECT),
        .din   (entry),
        .dout  (head),
        .count (count),
        .full  (full),
        .empty (empty)
    );

    assign DE_VALID   = !empty;
    assign DE_PC      = head.pc;
    assign DE_IR      = head.ir;
    assign DE_PCPLUS4 = head.pc + INSTR_BYTES;
    assign BUF_COUNT  = count;

    overflow_check: assert property (@(posedge CLK) disable iff (!RST_N) !(push && full));

endmodule

// File: tb/tb_otter_fetch_buffer.sv
// Scoreboard bench for otter_fetch_buffer: directed phases push expected {pc, ir}
// entries, a negedge monitor compares every entry decode actually consumes.
module tb_otter_fetch_buffer;
    import otter_fetch_pkg::*;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic [31:0] IMEM_ADDR;
    logic        IMEM_RDEN;
    logic [31:0] IMEM_DOUT = 32'h0;
    logic        REDIRECT;
    logic [31:0] REDIRECT_PC;
    logic        DE_READY;
    logic        DE_VALID;
    logic [31:0] DE_PC;
    logic [31:0] DE_IR;
    logic [31:0] DE_PCPLUS4;
    logic [2:0]  BUF_COUNT;

    fetch_entry_t exp_q[$];
    int checks    = 0;
    int failures  = 0;
    int consumed  = 0;

    otter_fetch_buffer #(
        .DEPTH    (4),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .CLK         (CLK),
        .RST_N       (RST_N),
        .IMEM_ADDR   (IMEM_ADDR),
        .IMEM_RDEN   (IMEM_RDEN),
        .IMEM_DOUT   (IMEM_DOUT),
        .REDIRECT    (REDIRECT),
        .REDIRECT_PC (REDIRECT_PC),
        .DE_READY    (DE_READY),
        .DE_VALID    (DE_VALID),
        .DE_PC       (DE_PC),
        .DE_IR       (DE_IR),
        .DE_PCPLUS4  (DE_PCPLUS4),
        .BUF_COUNT   (BUF_COUNT)
    );

    always #5 CLK = ~CLK;

    // Synchronous instruction memory: each word is its own address tagged with A5A5.
    always @(posedge CLK) begin
        if (IMEM_RDEN) IMEM_DOUT <= IMEM_ADDR ^ 32'hA5A5_0000;
    end

    task automatic check_value(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%h required=%h", name, actual, expected);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic push_stream(input logic [31:0] start, input int n);
        logic [31:0] pc;
        pc = start;
        for (int i = 0; i < n; i++) begin
            exp_q.push_back('{pc: pc, ir: pc ^ 32'hA5A5_0000});
            pc = pc + 32'd4;
        end
    endtask

    // Monitor: every accepted head entry must match the front of the expected queue.
    always @(negedge CLK) begin
        fetch_entry_t exp;
        if (RST_N && DE_VALID && DE_READY && !REDIRECT) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL pop_unexpected actual_pc=%h required=no_entry", DE_PC);
            end else begin
                exp = exp_q.pop_front();
                check_value("pop_pc", DE_PC, exp.pc);
                check_value("pop_ir", DE_IR, exp.ir);
                check_value("pop_pcplus4", DE_PCPLUS4, exp.pc + 32'd4);
                consumed++;
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        RST_N       = 1'b0;
        REDIRECT    = 1'b0;
        REDIRECT_PC = 32'h0;
        DE_READY    = 1'b1;
        step();
        step();

        // Reset values
        check_value("rst_valid", 32'(DE_VALID), 32'd0);
        check_value("rst_pc", DE_PC, 32'h0);
        check_value("rst_ir", DE_IR, 32'h0);
        check_value("rst_pcplus4", DE_PCPLUS4, 32'h4);
        check_value("rst_count", 32'(BUF_COUNT), 32'd0);
        check_value("rst_rden", 32'(IMEM_RDEN), 32'd0);

        // Phase A: reset release, decode always ready
        consumed = 0;
        push_stream(32'h0, 64);
        RST_N = 1'b1;
        #1;
        check_value("a_rden0", 32'(IMEM_RDEN), 32'd1);
        check_value("a_addr0", IMEM_ADDR, 32'h0);
        step();
        check_value("a_addr1", IMEM_ADDR, 32'h4);
        check_value("a_valid1", 32'(DE_VALID), 32'd0);
        step();
        check_value("a_addr2", IMEM_ADDR, 32'h8);
        check_value("a_valid2", 32'(DE_VALID), 32'd1);
        check_value("a_pc2", DE_PC, 32'h0);
        check_value("a_ir2", DE_IR, 32'hA5A5_0000);
        repeat (8) step();
        check_value("a_consumed", 32'(consumed), 32'd8);
        check_value("a_head", DE_PC, 32'd32);

        // Phase B: mid-stream reset, then decode stalled for 10 cycles
        RST_N = 1'b0;
        #1;
        check_value("b_rst_valid", 32'(DE_VALID), 32'd0);
        check_value("b_rst_count", 32'(BUF_COUNT), 32'd0);
        check_value("b_rst_rden", 32'(IMEM_RDEN), 32'd0);
        exp_q.delete();
        consumed = 0;
        DE_READY = 1'b0;
        step();
        step();
        push_stream(32'h0, 64);
        RST_N = 1'b1;
        repeat (10) step();
        check_value("b_full_count", 32'(BUF_COUNT), 32'd4);
        check_value("b_full_rden", 32'(IMEM_RDEN), 32'd0);
        check_value("b_full_valid", 32'(DE_VALID), 32'd1);
        check_value("b_full_head", DE_PC, 32'h0);
        check_value("b_full_consumed", 32'(consumed), 32'd0);
        DE_READY = 1'b1;
        #1;
        check_value("b_release_rden", 32'(IMEM_RDEN), 32'd1);
        check_value("b_release_addr", IMEM_ADDR, 32'd16);
        repeat (6) step();
        check_value("b_drain_consumed", 32'(consumed), 32'd6);
        check_value("b_drain_head", DE_PC, 32'd24);
        check_value("b_drain_count", 32'(BUF_COUNT), 32'd3);

        // Phase C: redirect with 3 queued + 1 in flight, decode ready and head valid
        REDIRECT    = 1'b1;
        REDIRECT_PC = 32'h0000_0100;
        exp_q.delete();
        consumed = 0;
        push_stream(32'h0000_0100, 16);
        #1;
        check_value("c_addr", IMEM_ADDR, 32'h0000_0100);
        check_value("c_rden", 32'(IMEM_RDEN), 32'd1);
        check_value("c_valid_before", 32'(DE_VALID), 32'd1);
        step();
        REDIRECT = 1'b0;
        #1;
        check_value("c_count_cleared", 32'(BUF_COUNT), 32'd0);
        check_value("c_valid_cleared", 32'(DE_VALID), 32'd0);
        step();
        check_value("c_target_valid", 32'(DE_VALID), 32'd1);
        check_value("c_target_pc", DE_PC, 32'h0000_0100);
        step();
        check_value("c_consumed", 32'(consumed), 32'd1);
        check_value("c_next_pc", DE_PC, 32'h0000_0104);

        // Phase D: misaligned redirect target, decode stalled
        DE_READY    = 1'b0;
        REDIRECT    = 1'b1;
        REDIRECT_PC = 32'h0000_0203;
        exp_q.delete();
        consumed = 0;
        push_stream(32'h0000_0200, 16);
        #1;
        check_value("d_addr", IMEM_ADDR, 32'h0000_0200);
        step();
        REDIRECT = 1'b0;
        step();
        check_value("d_valid", 32'(DE_VALID), 32'd1);
        check_value("d_pc", DE_PC, 32'h0000_0200);
        check_value("d_pcplus4", DE_PCPLUS4, 32'h0000_0204);
        check_value("d_ir", DE_IR, 32'hA5A5_0200);

        // Phase E: fetch PC wraps past the top of the address space
        REDIRECT    = 1'b1;
        REDIRECT_PC = 32'hFFFF_FFFC;
        exp_q.delete();
        consumed = 0;
        push_stream(32'hFFFF_FFFC, 16);
        #1;
        check_value("e_addr_top", IMEM_ADDR, 32'hFFFF_FFFC);
        step();
        REDIRECT = 1'b0;
        #1;
        check_value("e_addr_wrap", IMEM_ADDR, 32'h0);
        check_value("e_rden_wrap", 32'(IMEM_RDEN), 32'd1);
        step();
        check_value("e_pc_top", DE_PC, 32'hFFFF_FFFC);
        check_value("e_pcplus4_wrap", DE_PCPLUS4, 32'h0);
        DE_READY = 1'b1;
        repeat (4) step();
        check_value("e_consumed", 32'(consumed), 32'd4);
        check_value("e_head", DE_PC, 32'h0000_000C);

        // Phase F: reset pulse mid-stream, fetch restarts at RESET_PC
        RST_N = 1'b0;
        #1;
        check_value("f_rst_valid", 32'(DE_VALID), 32'd0);
        check_value("f_rst_rden", 32'(IMEM_RDEN), 32'd0);
        exp_q.delete();
        consumed = 0;
        push_stream(32'h0, 16);
        step();
        step();
        RST_N = 1'b1;
        #1;
        check_value("f_addr0", IMEM_ADDR, 32'h0);
        step();
        step();
        check_value("f_valid", 32'(DE_VALID), 32'd1);
        check_value("f_pc", DE_PC, 32'h0);
        repeat (3) step();
        check_value("f_consumed", 32'(consumed), 32'd3);
        check_value("f_head", DE_PC, 32'h0000_000C);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/otter_fetch_buffer.md
Name: otter_fetch_buffer

Overview:
- Instruction-fetch front end feeding the decode stage of the pipelined OTTER core.
- Owns the fetch PC and issues reads to the instruction port of the synchronous memory, which returns data one cycle after the read is enabled.
- Queues returned words with their PCs in a small FIFO and presents them to decode through a valid/ready handshake.
- Handles redirects from execute (taken branch or jump) by flushing queued and in-flight fetches, which replaces the stall/flush_hold bookkeeping in the core.

Parameters:
- DEPTH, 4, FIFO entries; power of two, minimum 2.
- RESET_PC, 32'h0000_0000, first fetch address after reset.

Ports:
- CLK  input  1  system clock, rising edge.
- RST_N  input  1  asynchronous active-low reset.
- IMEM_ADDR  output  32  instruction memory read address.
- IMEM_RDEN  output  1  instruction memory read enable; data is valid on IMEM_DOUT the next cycle.
- IMEM_DOUT  input  32  instruction word for the previous cycle's request.
- REDIRECT  input  1  execute requests a fetch redirect this cycle.
- REDIRECT_PC  input  32  target address; bits [1:0] are ignored and treated as 0.
- DE_READY  input  1  decode accepts the head entry this cycle.
- DE_VALID  output  1  head entry is valid.
- DE_PC  output  32  PC of the head entry.
- DE_IR  output  32  instruction word of the head entry.
- DE_PCPLUS4  output  32  DE_PC + 4, modulo 2^32.
- BUF_COUNT  output  $clog2(DEPTH)+1  occupied entries, for debug and performance counting.

Behaviour:
- Reset (RST_N low, asynchronous):
  - fpc = RESET_PC; count = 0; read/write pointers = 0; inflight = 0; kill = 0.
  - DE_VALID = 0, DE_PC = 0, DE_IR = 0, DE_PCPLUS4 = 4, BUF_COUNT = 0, IMEM_RDEN = 0.
  - The first request issues in the first clock edge cycle after RST_N rises.
  - Reset asserted mid-operation discards everything, including an in-flight response.
- Definitions:
  - pop = DE_VALID & DE_READY & !REDIRECT.
  - issue = REDIRECT | ((count + inflight - pop) < DEPTH). This is combinational and uses no FIFO memory.
- Request outputs:
  - IMEM_RDEN = issue.
  - IMEM_ADDR = REDIRECT ? {REDIRECT_PC[31:2], 2'b00} : fpc.
- On issue:
  - fpc <= IMEM_ADDR + 4, modulo 2^32, so 32'hFFFF_FFFC wraps to 0.
  - req_pc <= IMEM_ADDR.
  - inflight <= 1.
  - Otherwise inflight <= 0.
- Response cycle (inflight = 1):
  - If kill = 0 and REDIRECT = 0, push {req_pc, IMEM_DOUT} at the write pointer.
  - Otherwise drop the word.
  - kill is cleared after one cycle.
- REDIRECT (highest priority):
  - Pointers and count are cleared.
  - A pop in the same cycle is ignored; decode must not consume a head entry during a redirect cycle.
  - A response arriving in the same cycle is dropped.
  - The new target is issued in the same cycle.
  - kill <= 0, because the response due next cycle belongs to the target.
- Latency:
  - Redirect at cycle t: request issues at t, data returns at t+1, DE_VALID = 1 at t+2 with DE_PC = target.
  - Reset release behaves the same way: DE_VALID first rises 2 cycles after the first issue.
- Throughput: DE_READY held at 1 sustains one instruction per cycle for any DEPTH >= 2.
- Simultaneous push and pop: count is unchanged and both pointers advance.
- Full/empty:
  - The credit rule guarantees no push occurs when count = DEPTH.
  - An overflow attempt is an assertion failure.
  - DE_VALID = (count != 0).
  - DE_PC, DE_IR and DE_PCPLUS4 hold their last value when empty.
- Pointer wrap-around: pointers are $clog2(DEPTH) bits and wrap naturally. count is tracked separately.
- DE_READY while DE_VALID = 0 has no effect.

Decomposition:
- Package otter_fetch_pkg:
  - fetch_entry_t, packed, containing pc[31:0] and ir[31:0].
  - Constant INSTR_BYTES = 4.
  - Shares opcode_t with the core package.
- Sub-module otter_fetch_fifo, parameterised by DEPTH, with:
  - Inputs push, pop, clear, din as fetch_entry_t.
  - Outputs dout, count, full, empty.
- The parent owns fpc, inflight, kill and issue logic.

Test Plan:
- Reset release with DE_READY = 1 and memory returning word = address ^ 32'hA5A5_0000:
  - IMEM_ADDR sequence is 0, 4, 8, ...
  - DE_VALID rises at cycle 2 with DE_PC = 0 and DE_IR = 32'hA5A5_0000, then one entry per cycle.
- DE_READY = 0 for 10 cycles, DEPTH = 4:
  - BUF_COUNT saturates at 4 and IMEM_RDEN drops.
  - Entries for PCs 0, 4, 8, 12 are retained.
  - On release they drain in order with no duplicate or skipped PC.
- REDIRECT with REDIRECT_PC = 32'h0000_0100 while 3 entries are queued and one request is in flight:
  - BUF_COUNT = 0 the next cycle.
  - The stale word is never presented.
  - Two cycles later DE_PC = 0x100, followed by 0x104.
- REDIRECT asserted together with DE_READY = 1 and DE_VALID = 1:
  - The head entry is not consumed.
  - The next presented PC is the target.
- REDIRECT_PC = 32'h0000_0203:
  - IMEM_ADDR = 32'h0000_0200.
  - DE_PCPLUS4 = 32'h0000_0204.
- fpc at 32'hFFFF_FFFC:
  - The next IMEM_ADDR is 32'h0000_0000.
  - RST_N pulsed low mid-stream: DE_VALID goes to 0 immediately (asynchronously), and after release fetch restarts at RESET_PC.
